// File: rtl/jtdsp16_pkg.sv
// Shared definitions for the DSP16 loop engine: state encoding and do_data field layout.
package jtdsp16_pkg;

  localparam int unsigned NIW_DEF = 4;
  localparam int unsigned KW_DEF  = 7;

  // do_data = {NI, K}
  localparam int unsigned K_LSB  = 0;
  localparam int unsigned K_MSB  = KW_DEF - 1;
  localparam int unsigned NI_LSB = KW_DEF;
  localparam int unsigned NI_MSB = KW_DEF + NIW_DEF - 1;

  typedef enum logic [1:0] {
    LOOP_IDLE   = 2'd0,
    LOOP_FILL   = 2'd1,
    LOOP_REPLAY = 2'd2
  } loop_state_t;

endpackage

// File: rtl/jtdsp16_loop_ram.sv
// Loop body cache: one synchronous write port, one asynchronous read port.
module jtdsp16_loop_ram #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 15,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] din,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] dout
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= din;
  end

  assign dout = mem[raddr];

endmodule

// File: rtl/jtdsp16_loop.sv
// do/redo loop engine: captures the body from ROM, then replays it from a local cache.
// Build option: define JTDSP16_LOOP_REDO_EN to support redo (NI=0) from the cached body.
module jtdsp16_loop
  import jtdsp16_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 15,
  parameter int unsigned NIW   = NIW_DEF,
  parameter int unsigned KW    = KW_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cen,
  input  logic              do_start,
  input  logic [NIW+KW-1:0] do_data,
  input  logic              ins_take,
  input  logic [DW-1:0]     rom_dout,
  output logic [DW-1:0]     cache_dout,
  output logic              up_xcache,
  output logic              pc_hold,
  output logic              loop_busy,
  output logic              loop_end,
  output logic              fault
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loop_state_t    state;
  logic [NIW-1:0] ni;
  logic [KW-1:0]  iter;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [DW-1:0]  ram_dout;

  logic [NIW-1:0] ni_in;
  logic [KW-1:0]  k_in;
  logic           is_redo;
  logic           redo_ok;
  logic           cmd_ok;
  logic [PW-1:0]  last_ptr;
  logic           ram_we;

  assign ni_in    = do_data[NIW+KW-1:KW];
  assign k_in     = do_data[KW-1:0];
  assign is_redo  = (ni_in == '0);
  assign cmd_ok   = is_redo ? redo_ok : (32'(ni_in) <= DEPTH);
  assign last_ptr = PW'(ni - NIW'(1));
  assign ram_we   = cen && ins_take && (state == LOOP_FILL);

`ifdef JTDSP16_LOOP_REDO_EN
  logic cache_valid;

  // Cache holds a complete body once a fill pass finishes; a new do invalidates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_valid <= 1'b0;
    end else if (cen) begin
      if (state == LOOP_IDLE && do_start && cmd_ok && !is_redo && k_in != '0)
        cache_valid <= 1'b0;
      else if (state == LOOP_FILL && ins_take && wr_ptr == last_ptr)
        cache_valid <= 1'b1;
    end
  end

  assign redo_ok = cache_valid;
`else
  assign redo_ok = 1'b0;
`endif

  jtdsp16_loop_ram #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .AW    (PW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (wr_ptr),
    .din   (rom_dout),
    .raddr (rd_ptr),
    .dout  (ram_dout)
  );

  // Zero outside replay so the decoder mux sees a clean word after reset.
  assign cache_dout = up_xcache ? ram_dout : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOOP_IDLE;
      up_xcache <= 1'b0;
      pc_hold   <= 1'b0;
      loop_busy <= 1'b0;
      loop_end  <= 1'b0;
      fault     <= 1'b0;
      ni        <= '0;
      iter      <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (cen) begin
      loop_end <= 1'b0;
      if (do_start && state != LOOP_IDLE) fault <= 1'b1;
      case (state)
        LOOP_IDLE: begin
          if (do_start) begin
            if (!cmd_ok) begin
              fault <= 1'b1;
            end else if (k_in == '0) begin
              loop_end <= 1'b1;
            end else if (is_redo) begin
              // Redo replays every pass from the cache, so it needs all K iterations.
              iter      <= k_in;
              rd_ptr    <= '0;
              state     <= LOOP_REPLAY;
              up_xcache <= 1'b1;
              pc_hold   <= 1'b1;
              loop_busy <= 1'b1;
            end else begin
              ni        <= ni_in;
              iter      <= k_in - KW'(1);
              wr_ptr    <= '0;
              state     <= LOOP_FILL;
              loop_busy <= 1'b1;
            end
          end
        end
        LOOP_FILL: begin
          if (ins_take) begin
            wr_ptr <= wr_ptr + PW'(1);
            if (wr_ptr == last_ptr) begin
              if (iter == '0) begin
                loop_end  <= 1'b1;
                state     <= LOOP_IDLE;
                loop_busy <= 1'b0;
              end else begin
                rd_ptr    <= '0;
                state     <= LOOP_REPLAY;
                up_xcache <= 1'b1;
                pc_hold   <= 1'b1;
              end
            end
          end
        end
        LOOP_REPLAY: begin
          if (ins_take) begin
            if (rd_ptr == last_ptr) begin
              rd_ptr <= '0;
              iter   <= iter - KW'(1);
              if (iter == KW'(1)) begin
                loop_end  <= 1'b1;
                state     <= LOOP_IDLE;
                up_xcache <= 1'b0;
                pc_hold   <= 1'b0;
                loop_busy <= 1'b0;
              end
            end else begin
              rd_ptr <= rd_ptr + PW'(1);
            end
          end
        end
        default: begin
          state     <= LOOP_IDLE;
          up_xcache <= 1'b0;
          pc_hold   <= 1'b0;
          loop_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtdsp16_loop.sv
// Directed bench for jtdsp16_loop with a scoreboard of expected take results.
module tb_jtdsp16_loop;
  import jtdsp16_pkg::*;

  localparam int unsigned DW  = 16;
  localparam int unsigned NIW = 4;
  localparam int unsigned KW  = 7;

  localparam logic [DW-1:0] WA   = 16'hA5A1;
  localparam logic [DW-1:0] WB   = 16'hB2B2;
  localparam logic [DW-1:0] WC   = 16'hC3C3;
  localparam logic [DW-1:0] WX   = 16'hDEAD;

  typedef struct packed {
    logic          xc;
    logic [DW-1:0] dout;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              cen;
  logic              do_start;
  logic [NIW+KW-1:0] do_data;
  logic              ins_take;
  logic [DW-1:0]     rom_dout;
  logic [DW-1:0]     cache_dout;
  logic              up_xcache;
  logic              pc_hold;
  logic              loop_busy;
  logic              loop_end;
  logic              fault;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  jtdsp16_loop dut (
    .clk        (clk),
    .rst        (rst),
    .cen        (cen),
    .do_start   (do_start),
    .do_data    (do_data),
    .ins_take   (ins_take),
    .rom_dout   (rom_dout),
    .cache_dout (cache_dout),
    .up_xcache  (up_xcache),
    .pc_hold    (pc_hold),
    .loop_busy  (loop_busy),
    .loop_end   (loop_end),
    .fault      (fault)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input logic exp_fault);
    chk({tag, ".busy"},  32'(loop_busy),  32'(1'b0));
    chk({tag, ".xc"},    32'(up_xcache),  32'(1'b0));
    chk({tag, ".hold"},  32'(pc_hold),    32'(1'b0));
    chk({tag, ".fault"}, 32'(fault),      32'(exp_fault));
  endtask

  task automatic do_cmd(input logic [NIW-1:0] ni, input logic [KW-1:0] k);
    do_data = '0;
    do_data[NI_MSB:NI_LSB] = ni;
    do_data[K_MSB:K_LSB]   = k;
    do_start = 1'b1;
    cyc();
    do_start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // One consumed instruction: expectation pushed on drive, popped after the edge.
  task automatic take(input logic [DW-1:0] word, input logic xc,
                      input logic [DW-1:0] dout, input logic last);
    exp_t e;
    sb.push_back(exp_t'{xc: xc, dout: dout, last: last});
    e = sb[0];
    chk("take.busy", 32'(loop_busy), 32'(1'b1));
    chk("take.xc",   32'(up_xcache), 32'(e.xc));
    chk("take.hold", 32'(pc_hold),   32'(e.xc));
    if (e.xc) chk("take.cache_dout", 32'(cache_dout), 32'(e.dout));
    ins_take = 1'b1;
    rom_dout = word;
    cyc();
    ins_take = 1'b0;
    rom_dout = WX;
    e = sb.pop_front();
    chk("take.loop_end", 32'(loop_end), 32'(e.last));
  endtask

  initial begin
    logic [4:0] ni16;
    ni16     = 5'd16;
    rst      = 1'b1;
    cen      = 1'b1;
    do_start = 1'b0;
    do_data  = '0;
    ins_take = 1'b0;
    rom_dout = '0;
    cyc();
    cyc();

    // Reset state
    chk_idle("reset", 1'b0);
    chk("reset.end",  32'(loop_end),   32'(1'b0));
    chk("reset.dout", 32'(cache_dout), 32'(16'h0));
    rst = 1'b0;
    cyc();

    // NI=16 does not fit the field; it lands on an invalid NI=0 with no cached body
    do_cmd(ni16[NIW-1:0], 7'd1);
    chk_idle("ni16", 1'b1);
    do_reset();
    chk("ni16.cleared", 32'(fault), 32'(1'b0));

    // NI=3, K=1: single pass straight from ROM
    do_cmd(4'd3, 7'd1);
    chk("k1.busy", 32'(loop_busy), 32'(1'b1));
    take(WA, 1'b0, '0, 1'b0);
    take(WB, 1'b0, '0, 1'b0);
    take(WC, 1'b0, '0, 1'b1);
    chk_idle("k1.done", 1'b0);
    cyc();
    chk("k1.end_pulse", 32'(loop_end), 32'(1'b0));

    // NI=2, K=4: one fill pass then three replays
    do_cmd(4'd2, 7'd4);
    take(WA, 1'b0, '0, 1'b0);
    take(WB, 1'b0, '0, 1'b0);
    for (int i = 0; i < 6; i++)
      take(WX, 1'b1, (i % 2 == 0) ? WA : WB, (i == 5) ? 1'b1 : 1'b0);
    chk_idle("k4.done", 1'b0);

    // Redo K=2 from the cached body
    do_cmd(4'd0, 7'd2);
`ifdef JTDSP16_LOOP_REDO_EN
    for (int i = 0; i < 4; i++)
      take(WX, 1'b1, (i % 2 == 0) ? WA : WB, (i == 3) ? 1'b1 : 1'b0);
    chk_idle("redo.done", 1'b0);
`else
    chk_idle("redo.off", 1'b1);
    do_reset();
`endif

    // K=0: empty loop
    do_cmd(4'd2, 7'd0);
    chk("k0.end", 32'(loop_end), 32'(1'b1));
    chk_idle("k0", 1'b0);
    cyc();
    chk("k0.end_pulse", 32'(loop_end), 32'(1'b0));

    // NI=2, K=3 with bodies A,C; do_start mid-replay, stalls, then reset
    do_cmd(4'd2, 7'd3);
    take(WA, 1'b0, '0, 1'b0);
    take(WC, 1'b0, '0, 1'b0);
    take(WX, 1'b1, WA, 1'b0);
    do_cmd(4'd1, 7'd1);
    chk("busy_do.fault", 32'(fault),      32'(1'b1));
    chk("busy_do.busy",  32'(loop_busy),  32'(1'b1));
    chk("busy_do.xc",    32'(up_xcache),  32'(1'b1));
    chk("busy_do.dout",  32'(cache_dout), 32'(WC));
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall.dout", 32'(cache_dout), 32'(WC));
      chk("stall.xc",   32'(up_xcache),  32'(1'b1));
    end
    cen = 1'b0;
    ins_take = 1'b1;
    cyc();
    cyc();
    ins_take = 1'b0;
    cen = 1'b1;
    chk("nocen.dout", 32'(cache_dout), 32'(WC));
    take(WX, 1'b1, WC, 1'b0);
    take(WX, 1'b1, WA, 1'b0);
    do_reset();
    chk_idle("rst_mid", 1'b0);
    chk("rst_mid.end",  32'(loop_end),   32'(1'b0));
    chk("rst_mid.dout", 32'(cache_dout), 32'(16'h0));

    // Reset drops the cached-body flag, so redo must fault
    do_cmd(4'd0, 7'd2);
    chk_idle("redo_after_rst", 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
